// File: rtl/systolic_job_sched_pkg.sv
// Shared types and sizing for the systolic job scheduler.
package systolic_ctrl_pkg;
  localparam int CHUNK_W  = 64;
  localparam int N_CHUNKS = 4;
  localparam int JOB_W    = CHUNK_W * N_CHUNKS;
  localparam int CI_W     = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VLD,
    ST_DAT,
    ST_SRC,
    ST_GAP,
    ST_WAIT,
    ST_RESP
  } sched_state_t;
endpackage

// File: rtl/systolic_job_sched_if.sv
// Requester and core-side handshake bundle of the systolic job scheduler.
interface systolic_job_sched_if;
  import systolic_ctrl_pkg::*;

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [JOB_W-1:0]   req_data0;
  logic [JOB_W-1:0]   req_data1;
  logic [1:0]         resp_valid;
  logic [1:0]         resp_ready;
  logic [CHUNK_W-1:0] resp_data;
  logic               resp_err;
  logic               core_valid_in;
  logic [CHUNK_W-1:0] core_data_in;
  logic               core_src_valid;
  logic               core_src_ready;
  logic [CHUNK_W-1:0] core_result;
  logic               core_done;

  modport slave (
    input  req_valid, req_data0, req_data1, resp_ready,
    input  core_src_ready, core_result, core_done,
    output req_ready, resp_valid, resp_data, resp_err,
    output core_valid_in, core_data_in, core_src_valid
  );

  modport master (
    output req_valid, req_data0, req_data1, resp_ready,
    output core_src_ready, core_result, core_done,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  core_valid_in, core_data_in, core_src_valid
  );
endinterface

// File: rtl/systolic_job_sched_rr_arbiter2.sv
// Two-way round-robin pick: requester rr wins if it asks, else the other one.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rr,
  input  logic       en,
  output logic [1:0] grant,
  output logic       win
);
  always_comb begin
    win   = req[rr] ? rr : ~rr;
    grant = 2'b00;
    if (en && (req != 2'b00)) grant[win] = 1'b1;
  end
endmodule

// File: rtl/systolic_job_sched.sv
// Job-level front end for the systolic core: arbitrates, replays chunks, returns result.
// IDLE wait job | VLD valid_in pulse | DAT drive chunk | SRC src handshake | GAP next chunk | WAIT done/timeout | RESP return
module systolic_job_sched
  import systolic_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic reset,
  systolic_job_sched_if.slave bus,
  output logic busy
);
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [CI_W-1:0]  CI_LAST  = CI_W'(N_CHUNKS - 1);

  sched_state_t       state, state_nxt;
  logic               rr, owner, win, accept, resp_hs, tmo_hit;
  logic [1:0]         grant;
  logic [JOB_W-1:0]   job_buf;
  logic [CI_W-1:0]    ci;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [CHUNK_W-1:0] data_q, resp_data_q;
  logic               resp_err_q;

  rr_arbiter2 u_arb (
    .req   (bus.req_valid),
    .rr    (rr),
    .en    (state == ST_IDLE),
    .grant (grant),
    .win   (win)
  );

  assign accept  = (grant != 2'b00);
  assign resp_hs = (state == ST_RESP) && bus.resp_ready[owner];
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_VLD;
      ST_VLD:  state_nxt = ST_DAT;
      ST_DAT:  state_nxt = ST_SRC;
      ST_SRC:  if (bus.core_src_ready) state_nxt = (ci == CI_LAST) ? ST_WAIT : ST_GAP;
      ST_GAP:  state_nxt = ST_VLD;
      ST_WAIT: if (bus.core_done || tmo_hit) state_nxt = ST_RESP;
      ST_RESP: if (resp_hs) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready      = 2'b00;
    bus.resp_valid     = 2'b00;
    bus.core_valid_in  = 1'b0;
    bus.core_src_valid = 1'b0;
    busy               = 1'b1;
    case (state)
      ST_IDLE: begin
        busy          = 1'b0;
        bus.req_ready = grant;
      end
      ST_VLD:  bus.core_valid_in  = 1'b1;
      ST_SRC:  bus.core_src_valid = 1'b1;
      ST_RESP: bus.resp_valid     = owner ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  assign bus.core_data_in = data_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_err     = resp_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr          <= 1'b0;
      owner       <= 1'b0;
      job_buf     <= '0;
      ci          <= '0;
      tmo_cnt     <= '0;
      data_q      <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        owner   <= win;
        job_buf <= win ? bus.req_data1 : bus.req_data0;
        ci      <= '0;
      end
      // chunk is loaded while in VLD so it appears on data_in exactly in DAT
      if (state == ST_VLD) data_q <= job_buf[ci*CHUNK_W +: CHUNK_W];
      if (state == ST_GAP) ci <= ci + CI_W'(1);
      tmo_cnt <= (state == ST_WAIT) ? tmo_cnt + TMO_W'(1) : '0;
      if (state == ST_WAIT) begin
        if (bus.core_done) begin
          resp_data_q <= bus.core_result;
          resp_err_q  <= 1'b0;
        end else if (tmo_hit) begin
          resp_data_q <= '0;
          resp_err_q  <= 1'b1;
        end
      end
      if (resp_hs) rr <= ~owner;
    end
  end
endmodule

// File: tb/tb_systolic_job_sched.sv
// Self-checking bench: cycle table for one job, hand sequences for corners, random jobs vs a transaction model.
module tb_systolic_job_sched;
  logic clk = 1'b0;
  logic rst;
  logic busy_a, busy_b;
  logic use_b;
  int   checks = 0;
  int   errors = 0;

  systolic_job_sched_if ia ();
  systolic_job_sched_if ib ();

  systolic_job_sched dut_a (.clk(clk), .reset(rst), .bus(ia.slave), .busy(busy_a));
  systolic_job_sched #(.TIMEOUT_CYC(16)) dut_b (.clk(clk), .reset(rst), .bus(ib.slave), .busy(busy_b));

  assign ib.req_valid      = ia.req_valid;
  assign ib.req_data0      = ia.req_data0;
  assign ib.req_data1      = ia.req_data1;
  assign ib.resp_ready     = ia.resp_ready;
  assign ib.core_src_ready = ia.core_src_ready;
  assign ib.core_result    = ia.core_result;
  assign ib.core_done      = ia.core_done;

  logic [1:0]  o_req_ready, o_resp_valid;
  logic [63:0] o_resp_data, o_data_in;
  logic        o_resp_err, o_valid_in, o_src_valid, o_busy;

  always_comb begin
    o_req_ready  = use_b ? ib.req_ready      : ia.req_ready;
    o_resp_valid = use_b ? ib.resp_valid     : ia.resp_valid;
    o_resp_data  = use_b ? ib.resp_data      : ia.resp_data;
    o_resp_err   = use_b ? ib.resp_err       : ia.resp_err;
    o_valid_in   = use_b ? ib.core_valid_in  : ia.core_valid_in;
    o_src_valid  = use_b ? ib.core_src_valid : ia.core_src_valid;
    o_data_in    = use_b ? ib.core_data_in   : ia.core_data_in;
    o_busy       = use_b ? busy_b            : busy_a;
  end

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        src_ready;
    logic        exp_vld;
    logic        exp_src;
    logic        exp_busy;
    logic [63:0] exp_data;
  } vec_t;

  vec_t tbl [1:16];

  task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    ia.req_valid = 2'b00;
    ia.resp_ready = 2'b00;
    ia.core_src_ready = 1'b1;
    ia.core_done = 1'b0;
    ia.core_result = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One full job from accept to response handshake, checked against the spec's transaction rules.
  task automatic run_job(input string nm, input logic [1:0] exp_gnt, input logic [255:0] pay,
                         input logic [63:0] res, input bit give_done, input int done_dly,
                         input int exp_wait, input logic exp_err, input int bp_chunk,
                         input int bp_len, input bit rnd_rdy, input bit spur, input int stall);
    int guard, k, bad, wcnt, hold;
    int sv [4];
    logic [31:0] exp_sv;
    logic [63:0] exp_data;
    guard = 0;
    #1;
    while (o_req_ready == 2'b00 && guard < 100) begin
      tick();
      #1;
      guard++;
    end
    check({nm, " grant"}, {o_req_ready, 32'(guard)}, {exp_gnt, 32'd0});
    tick();
    k = 0;
    bad = 0;
    guard = 0;
    sv = '{default: 0};
    while (k < 4 && guard < 400) begin
      if (rnd_rdy) ia.core_src_ready = ($urandom_range(0, 3) != 0);
      else         ia.core_src_ready = !(k == bp_chunk && sv[k] < bp_len);
      ia.core_done = spur;
      #1;
      if (o_req_ready != 2'b00 || o_resp_valid != 2'b00 || !o_busy) bad++;
      if (o_src_valid) begin
        sv[k]++;
        if (o_data_in !== pay[k*64 +: 64]) bad++;
        if (ia.core_src_ready) k++;
      end
      tick();
      guard++;
    end
    check({nm, " chunks"}, {32'(k), 32'(bad)}, {32'd4, 32'd0});
    if (!rnd_rdy) begin
      for (int i = 0; i < 4; i++) exp_sv[(3-i)*8 +: 8] = 8'(1 + ((i == bp_chunk) ? bp_len : 0));
      check({nm, " src cycles"}, {8'(sv[0]), 8'(sv[1]), 8'(sv[2]), 8'(sv[3])}, exp_sv);
    end
    ia.core_src_ready = 1'b1;
    wcnt = 0;
    while (wcnt < 3000) begin
      ia.core_done = give_done && (wcnt == done_dly);
      ia.core_result = (wcnt == done_dly) ? res : (64'hDEAD_0000_0000_0000 ^ 64'(wcnt));
      #1;
      if (o_resp_valid != 2'b00) break;
      tick();
      wcnt++;
    end
    ia.core_done = 1'b0;
    check({nm, " wait cycles"}, 32'(wcnt), 32'(exp_wait));
    exp_data = exp_err ? 64'd0 : res;
    check({nm, " response"}, {o_resp_valid, o_resp_err, o_resp_data}, {exp_gnt, exp_err, exp_data});
    hold = 0;
    guard = 0;
    while (guard < 50) begin
      ia.resp_ready = (hold >= stall) ? exp_gnt : 2'b00;
      #1;
      if (o_resp_valid == exp_gnt && o_resp_data === exp_data && o_resp_err === exp_err) hold++;
      if (ia.resp_ready != 2'b00) begin
        tick();
        break;
      end
      tick();
      guard++;
    end
    ia.resp_ready = 2'b00;
    #1;
    check({nm, " resp hold"}, 32'(hold), 32'(stall + 1));
    check({nm, " idle after"}, {o_busy, o_resp_valid}, 3'b000);
  endtask

  logic [63:0]  ch [4];
  logic [255:0] p0, p1, d0, d1;
  logic [1:0]   rv;
  logic         rr_m, win;
  int           dly;

  initial begin
    use_b = 1'b0;
    ia.req_data0 = '0;
    ia.req_data1 = '0;
    ch[0] = 64'h1234567890ABCDEF;
    ch[1] = 64'h8911223344556677;
    ch[2] = 64'h8899AABBCCDDEEFF;
    ch[3] = 64'h1020304050607080;
    for (int o = 1; o <= 16; o++) begin
      tbl[o].src_ready = 1'b1;
      tbl[o].exp_vld   = (o < 16) && ((o - 1) % 4 == 0);
      tbl[o].exp_src   = (o < 16) && ((o - 1) % 4 == 2);
      tbl[o].exp_busy  = 1'b1;
      tbl[o].exp_data  = (o == 1) ? 64'd0 : ch[(o - 2) / 4];
    end

    // reset state on both instances
    do_reset();
    #1;
    check("reset a", {ia.req_ready, ia.resp_valid, ia.resp_err, ia.resp_data, ia.core_valid_in,
                      ia.core_src_valid, ia.core_data_in, busy_a}, '0);
    check("reset b", {ib.req_ready, ib.resp_valid, ib.resp_err, ib.resp_data, ib.core_valid_in,
                      ib.core_src_valid, ib.core_data_in, busy_b}, '0);

    // single job, cycle-exact pattern from the table
    ia.req_data0 = {ch[3], ch[2], ch[1], ch[0]};
    ia.req_valid = 2'b01;
    #1;
    check("single accept", {o_req_ready, o_busy}, {2'b01, 1'b0});
    tick();
    ia.req_valid = 2'b00;
    for (int o = 1; o <= 16; o++) begin
      ia.core_src_ready = tbl[o].src_ready;
      #1;
      check($sformatf("single cycle t+%0d", o), {o_valid_in, o_src_valid, o_busy, o_data_in},
            {tbl[o].exp_vld, tbl[o].exp_src, tbl[o].exp_busy, tbl[o].exp_data});
      tick();
    end
    repeat (18) tick();
    ia.core_done = 1'b1;
    ia.core_result = 64'hCAFEF00DDEADBEEF;
    #1;
    check("single before done", o_resp_valid, 2'b00);
    tick();
    ia.core_done = 1'b0;
    ia.core_result = 64'h0;
    #1;
    check("single response", {o_resp_valid, o_resp_err, o_resp_data}, {2'b01, 1'b0, 64'hCAFEF00DDEADBEEF});
    ia.resp_ready = 2'b01;
    #1;
    tick();
    ia.resp_ready = 2'b00;
    #1;
    check("single idle", {o_busy, o_resp_valid}, 3'b000);

    // contention: both requesters from reset
    p0 = rand256();
    p1 = rand256();
    do_reset();
    ia.req_data0 = p0;
    ia.req_data1 = p1;
    ia.req_valid = 2'b11;
    run_job("cont0", 2'b01, p0, 64'hA0A0_0000_1111_0001, 1, 3, 4, 1'b0, -1, 0, 0, 1, 0);
    run_job("cont1", 2'b10, p1, 64'hB1B1_0000_2222_0002, 1, 0, 1, 1'b0, -1, 0, 0, 1, 0);
    run_job("cont2", 2'b01, p0, 64'hC2C2_0000_3333_0003, 1, 7, 8, 1'b0, -1, 0, 0, 0, 1);
    ia.req_valid = 2'b00;

    // backpressure on chunk 2
    do_reset();
    ia.req_valid = 2'b01;
    run_job("backpressure", 2'b01, p0, 64'h0123_4567_89AB_CDEF, 1, 5, 6, 1'b0, 2, 5, 0, 0, 0);
    ia.req_valid = 2'b00;

    // timeout and done-on-timeout-cycle on the short-timeout instance
    use_b = 1'b1;
    do_reset();
    ia.req_valid = 2'b01;
    run_job("timeout", 2'b01, p0, 64'h5555_6666_7777_8888, 0, 0, 16, 1'b1, -1, 0, 0, 0, 0);
    ia.req_valid = 2'b00;
    do_reset();
    ia.req_valid = 2'b10;
    run_job("simul", 2'b10, p1, 64'h9999_AAAA_BBBB_CCCC, 1, 15, 16, 1'b0, -1, 0, 0, 0, 3);
    ia.req_valid = 2'b00;
    use_b = 1'b0;

    // reset mid-job during SRC of chunk 1
    do_reset();
    ia.req_valid = 2'b01;
    run_job("pre reset", 2'b01, p0, 64'h1357_9BDF_0246_8ACE, 1, 2, 3, 1'b0, -1, 0, 0, 0, 0);
    ia.req_valid = 2'b11;
    #1;
    check("mid grant", o_req_ready, 2'b10);
    tick();
    repeat (6) tick();
    #1;
    check("mid src chunk1", {o_src_valid, o_data_in}, {1'b1, p1[127:64]});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ia.req_valid = 2'b00;
    #1;
    check("mid reset outputs", {o_req_ready, o_resp_valid, o_resp_err, o_resp_data, o_valid_in,
                                o_src_valid, o_data_in, o_busy}, '0);
    ia.req_valid = 2'b11;
    run_job("post reset", 2'b01, p0, 64'h2468_ACE0_1357_9BDF, 1, 4, 5, 1'b0, -1, 0, 0, 0, 0);
    ia.req_valid = 2'b00;

    // random jobs against a transaction-level model of the round-robin owner
    do_reset();
    rr_m = 1'b0;
    for (int j = 0; j < 30; j++) begin
      d0 = rand256();
      d1 = rand256();
      rv = 2'($urandom_range(1, 3));
      dly = $urandom_range(0, 40);
      ia.req_data0 = d0;
      ia.req_data1 = d1;
      ia.req_valid = rv;
      win = rv[rr_m] ? rr_m : ~rr_m;
      run_job($sformatf("rand%0d", j), win ? 2'b10 : 2'b01, win ? d1 : d0,
              {$urandom, $urandom}, 1, dly, dly + 1, 1'b0, -1, 0, 1,
              1'($urandom_range(0, 1)), $urandom_range(0, 3));
      rr_m = ~win;
    end
    ia.req_valid = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
